// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: 2 combinational read ports, 2 prioritised
// write ports, same-cycle write-to-read bypass and a per-register pending scoreboard.
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] rIdx1,
    input  logic [ADDR_W-1:0] rIdx2,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wEn0,
    input  logic [ADDR_W-1:0] wIdx0,
    input  logic [DATA_W-1:0] wData0,
    input  logic              wEn1,
    input  logic [ADDR_W-1:0] wIdx1,
    input  logic [DATA_W-1:0] wData1,
    input  logic              rsvEn,
    input  logic [ADDR_W-1:0] rsvIdx,
    output logic              wConf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pend_nxt;
    logic              collide;
    logic              hit1_0, hit1_1, hit2_0, hit2_1;

    assign collide = wEn0 && wEn1 && (wIdx0 == wIdx1) &&
                     !((ZERO_REG != 0) && (wIdx0 == '0));

    // Reserve is applied after the write clears so set wins on the same index.
    always_comb begin
        pend_nxt = pending;
        if (wEn0) pend_nxt[wIdx0] = 1'b0;
        if (wEn1) pend_nxt[wIdx1] = 1'b0;
        if (rsvEn) pend_nxt[rsvIdx] = 1'b1;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending <= '0;
            wConf   <= 1'b0;
        end else begin
            if (wEn0) regs[wIdx0] <= wData0;
            if (wEn1) regs[wIdx1] <= wData1;
            if (ZERO_REG != 0) regs[0] <= '0;
            pending <= pend_nxt;
            if (collide) wConf <= 1'b1;
        end
    end

    always_comb begin
        hit1_0 = (BYPASS != 0) && wEn0 && (wIdx0 == rIdx1);
        hit1_1 = (BYPASS != 0) && wEn1 && (wIdx1 == rIdx1);
        read1  = regs[rIdx1];
        if (hit1_1)      read1 = wData1;
        else if (hit1_0) read1 = wData0;
        busy1 = pending[rIdx1] && !(hit1_0 || hit1_1);
        if (((ZERO_REG != 0) && (rIdx1 == '0)) || !RST) begin
            read1 = '0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        hit2_0 = (BYPASS != 0) && wEn0 && (wIdx0 == rIdx2);
        hit2_1 = (BYPASS != 0) && wEn1 && (wIdx1 == rIdx2);
        read2  = regs[rIdx2];
        if (hit2_1)      read2 = wData1;
        else if (hit2_0) read2 = wData0;
        busy2 = pending[rIdx2] && !(hit2_0 || hit2_1);
        if (((ZERO_REG != 0) && (rIdx2 == '0)) || !RST) begin
            read2 = '0;
            busy2 = 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations (bypass, no bypass, zero-reg 16x8)
// checked against an array-based reference model.
module tb_reg_file_mp;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    // shared stimulus for the 8-bit x4 instances (A: BYPASS=1, B: BYPASS=0)
    logic [1:0] rIdx1 = '0, rIdx2 = '0, wIdx0 = '0, wIdx1 = '0, rsvIdx = '0;
    logic [7:0] wData0 = '0, wData1 = '0;
    logic       wEn0 = 1'b0, wEn1 = 1'b0, rsvEn = 1'b0;
    logic [7:0] a_read1, a_read2, b_read1, b_read2;
    logic       a_busy1, a_busy2, b_busy1, b_busy2, a_wConf, b_wConf;

    // zero-reg 16-bit x8 instance
    logic [2:0]  z_rIdx1 = '0, z_rIdx2 = '0, z_wIdx0 = '0, z_wIdx1 = '0, z_rsvIdx = '0;
    logic [15:0] z_wData0 = '0, z_wData1 = '0;
    logic        z_wEn0 = 1'b0, z_wEn1 = 1'b0, z_rsvEn = 1'b0;
    logic [15:0] z_read1, z_read2;
    logic        z_busy1, z_busy2, z_wConf;

    int vectors = 0;
    int miscompares = 0;

    reg_file_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .CLK(CLK), .RST(RST), .rIdx1(rIdx1), .rIdx2(rIdx2), .read1(a_read1), .read2(a_read2),
        .busy1(a_busy1), .busy2(a_busy2), .wEn0(wEn0), .wIdx0(wIdx0), .wData0(wData0),
        .wEn1(wEn1), .wIdx1(wIdx1), .wData1(wData1), .rsvEn(rsvEn), .rsvIdx(rsvIdx), .wConf(a_wConf));

    reg_file_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .RST(RST), .rIdx1(rIdx1), .rIdx2(rIdx2), .read1(b_read1), .read2(b_read2),
        .busy1(b_busy1), .busy2(b_busy2), .wEn0(wEn0), .wIdx0(wIdx0), .wData0(wData0),
        .wEn1(wEn1), .wIdx1(wIdx1), .wData1(wData1), .rsvEn(rsvEn), .rsvIdx(rsvIdx), .wConf(b_wConf));

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .CLK(CLK), .RST(RST), .rIdx1(z_rIdx1), .rIdx2(z_rIdx2), .read1(z_read1), .read2(z_read2),
        .busy1(z_busy1), .busy2(z_busy2), .wEn0(z_wEn0), .wIdx0(z_wIdx0), .wData0(z_wData0),
        .wEn1(z_wEn1), .wIdx1(z_wIdx1), .wData1(z_wData1), .rsvEn(z_rsvEn), .rsvIdx(z_rsvIdx),
        .wConf(z_wConf));

    // reference model state
    logic [7:0]  ma_reg [4];
    bit   [3:0]  ma_pend;
    bit          ma_conf;
    logic [15:0] mz_reg [8];
    bit   [7:0]  mz_pend;
    bit          mz_conf;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) ma_reg[i] = '0;
        for (int i = 0; i < 8; i++) mz_reg[i] = '0;
        ma_pend = '0; mz_pend = '0; ma_conf = 0; mz_conf = 0;
    endfunction

    // expected read value: newest same-cycle write (port 1 first) when forwarding
    function automatic logic [7:0] exp_a_read(input logic [1:0] idx, input bit byp);
        if (!RST) return '0;
        if (byp && wEn1 && wIdx1 == idx) return wData1;
        if (byp && wEn0 && wIdx0 == idx) return wData0;
        return ma_reg[idx];
    endfunction

    function automatic bit exp_a_busy(input logic [1:0] idx, input bit byp);
        if (!RST) return 0;
        if (byp && ((wEn1 && wIdx1 == idx) || (wEn0 && wIdx0 == idx))) return 0;
        return ma_pend[idx];
    endfunction

    function automatic logic [15:0] exp_z_read(input logic [2:0] idx);
        if (!RST || idx == 0) return '0;
        if (z_wEn1 && z_wIdx1 == idx) return z_wData1;
        if (z_wEn0 && z_wIdx0 == idx) return z_wData0;
        return mz_reg[idx];
    endfunction

    function automatic bit exp_z_busy(input logic [2:0] idx);
        if (!RST || idx == 0) return 0;
        if ((z_wEn1 && z_wIdx1 == idx) || (z_wEn0 && z_wIdx0 == idx)) return 0;
        return mz_pend[idx];
    endfunction

    // advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            if (wEn0 && wEn1 && wIdx0 == wIdx1) ma_conf = 1;
            if (wEn0) begin ma_reg[wIdx0] = wData0; ma_pend[wIdx0] = 0; end
            if (wEn1) begin ma_reg[wIdx1] = wData1; ma_pend[wIdx1] = 0; end
            if (rsvEn) ma_pend[rsvIdx] = 1;
            if (z_wEn0 && z_wEn1 && z_wIdx0 == z_wIdx1 && z_wIdx0 != 0) mz_conf = 1;
            if (z_wEn0 && z_wIdx0 != 0) begin mz_reg[z_wIdx0] = z_wData0; mz_pend[z_wIdx0] = 0; end
            if (z_wEn1 && z_wIdx1 != 0) begin mz_reg[z_wIdx1] = z_wData1; mz_pend[z_wIdx1] = 0; end
            if (z_rsvEn && z_rsvIdx != 0) mz_pend[z_rsvIdx] = 1;
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        wEn0 = 0; wEn1 = 0; rsvEn = 0;
        z_wEn0 = 0; z_wEn1 = 0; z_rsvEn = 0;
    endtask

    task automatic test_reset();
        RST = 0; model_clear();
        wEn0 = 1; wIdx0 = 2'd1; wData0 = 8'hAA; rIdx1 = 2'd1;
        tick();
        #1;
        vectors++;
        if (a_read1 !== 8'h00 || a_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_hold: read1=%h busy1=%b want 00/0", a_read1, a_busy1);
        end
        idle_inputs();
        RST = 1;
        #1;
        vectors++;
        if (a_read1 !== 8'h00) begin
            miscompares++; $display("FAIL reset_release: read1=%h want 00", a_read1);
        end
        vectors++;
        if (a_wConf !== 1'b0 || z_wConf !== 1'b0) begin
            miscompares++; $display("FAIL reset_wconf: a=%b z=%b want 0/0", a_wConf, z_wConf);
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [7:0] want;
        wEn0 = 1; wIdx0 = 2'd2; wData0 = 8'h5C;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rIdx1 = 2'(i);
            want = (i == 2) ? 8'h5C : 8'h00;
            #1;
            vectors++;
            if (a_read1 !== want) begin
                miscompares++; $display("FAIL write_read idx%0d: read1=%h want %h", i, a_read1, want);
            end
        end
    endtask

    task automatic test_collision();
        wEn0 = 1; wIdx0 = 2'd3; wData0 = 8'h11;
        wEn1 = 1; wIdx1 = 2'd3; wData1 = 8'h22;
        tick();
        idle_inputs();
        rIdx2 = 2'd3;
        #1;
        vectors++;
        if (a_read2 !== 8'h22) begin
            miscompares++; $display("FAIL collision_data: read2=%h want 22", a_read2);
        end
        vectors++;
        if (a_wConf !== 1'b1) begin
            miscompares++; $display("FAIL collision_wconf: wConf=%b want 1", a_wConf);
        end
        tick(); tick();
        vectors++;
        if (a_wConf !== 1'b1 || b_wConf !== 1'b1) begin
            miscompares++; $display("FAIL collision_sticky: a=%b b=%b want 1/1", a_wConf, b_wConf);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] old;
        old = ma_reg[1];
        wEn1 = 1; wIdx1 = 2'd1; wData1 = 8'h7E; rIdx2 = 2'd1;
        #1;
        vectors++;
        if (a_read2 !== 8'h7E) begin
            miscompares++; $display("FAIL bypass_on: read2=%h want 7e", a_read2);
        end
        vectors++;
        if (b_read2 !== old) begin
            miscompares++; $display("FAIL bypass_off: read2=%h want %h", b_read2, old);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        rsvEn = 1; rsvIdx = 2'd2; rIdx1 = 2'd2;
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (a_busy1 !== 1'b1 || b_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_reserve: a=%b b=%b want 1/1", a_busy1, b_busy1);
        end
        wEn0 = 1; wIdx0 = 2'd2; wData0 = 8'h33;
        #1;
        vectors++;
        if (a_busy1 !== 1'b0 || b_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_bypass_busy: a=%b b=%b want 0/1", a_busy1, b_busy1);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (a_busy1 !== 1'b0 || b_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL sb_cleared: a=%b b=%b want 0/0", a_busy1, b_busy1);
        end
        wEn0 = 1; wIdx0 = 2'd2; wData0 = 8'h44; rsvEn = 1; rsvIdx = 2'd2;
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (a_busy1 !== 1'b1 || b_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_set_wins: a=%b b=%b want 1/1", a_busy1, b_busy1);
        end
    endtask

    task automatic test_zero_reg();
        z_wEn0 = 1; z_wIdx0 = 3'd0; z_wData0 = 16'hBEEF;
        z_rsvEn = 1; z_rsvIdx = 3'd0; z_rIdx1 = 3'd0;
        #1;
        vectors++;
        if (z_read1 !== 16'h0000 || z_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL zero_same_cycle: read1=%h busy1=%b want 0000/0", z_read1, z_busy1);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (z_read1 !== 16'h0000 || z_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL zero_after: read1=%h busy1=%b want 0000/0", z_read1, z_busy1);
        end
        z_wEn0 = 1; z_wIdx0 = 3'd7; z_wData0 = 16'hBEEF; z_rIdx2 = 3'd7;
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (z_read2 !== 16'hBEEF) begin
            miscompares++; $display("FAIL zero_idx7: read2=%h want beef", z_read2);
        end
        z_wEn0 = 1; z_wIdx0 = 3'd0; z_wEn1 = 1; z_wIdx1 = 3'd0;
        tick();
        idle_inputs();
        vectors++;
        if (z_wConf !== 1'b0) begin
            miscompares++; $display("FAIL zero_no_wconf: wConf=%b want 0", z_wConf);
        end
    endtask

    task automatic test_reset_mid();
        rsvEn = 1; rsvIdx = 2'd1; wEn0 = 1; wIdx0 = 2'd3; wData0 = 8'h9D;
        #2 RST = 0; model_clear();
        #1;
        vectors++;
        if (a_read1 !== 8'h00 || a_read2 !== 8'h00 || a_busy1 !== 1'b0 || a_wConf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: read1=%h read2=%h busy1=%b wConf=%b want 00/00/0/0",
                     a_read1, a_read2, a_busy1, a_wConf);
        end
        tick();
        idle_inputs();
        RST = 1; rIdx1 = 2'd1; rIdx2 = 2'd3;
        #1;
        vectors++;
        if (a_busy1 !== 1'b0 || a_read2 !== 8'h00) begin
            miscompares++; $display("FAIL reset_mid_after: busy1=%b read2=%h want 0/00", a_busy1, a_read2);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rIdx1 = 2'($urandom); rIdx2 = (n % 7 == 0) ? rIdx1 : 2'($urandom);
            wEn0 = ($urandom_range(0, 2) != 0); wIdx0 = 2'($urandom); wData0 = 8'($urandom);
            wEn1 = ($urandom_range(0, 2) == 0); wIdx1 = 2'($urandom); wData1 = 8'($urandom);
            rsvEn = ($urandom_range(0, 1) != 0); rsvIdx = 2'($urandom);
            z_rIdx1 = 3'($urandom); z_rIdx2 = 3'($urandom);
            z_wEn0 = ($urandom_range(0, 2) != 0); z_wIdx0 = 3'($urandom); z_wData0 = 16'($urandom);
            z_wEn1 = ($urandom_range(0, 3) == 0); z_wIdx1 = 3'($urandom); z_wData1 = 16'($urandom);
            z_rsvEn = ($urandom_range(0, 1) != 0); z_rsvIdx = 3'($urandom);
            #1;
            vectors++;
            if (a_read1 !== exp_a_read(rIdx1, 1) || a_read2 !== exp_a_read(rIdx2, 1)) begin
                miscompares++;
                $display("FAIL rand_a_read n=%0d: got %h/%h want %h/%h", n, a_read1, a_read2,
                         exp_a_read(rIdx1, 1), exp_a_read(rIdx2, 1));
            end
            vectors++;
            if (a_busy1 !== exp_a_busy(rIdx1, 1) || a_busy2 !== exp_a_busy(rIdx2, 1)) begin
                miscompares++;
                $display("FAIL rand_a_busy n=%0d: got %b/%b want %b/%b", n, a_busy1, a_busy2,
                         exp_a_busy(rIdx1, 1), exp_a_busy(rIdx2, 1));
            end
            vectors++;
            if (b_read1 !== exp_a_read(rIdx1, 0) || b_busy2 !== exp_a_busy(rIdx2, 0)) begin
                miscompares++;
                $display("FAIL rand_b n=%0d: got %h/%b want %h/%b", n, b_read1, b_busy2,
                         exp_a_read(rIdx1, 0), exp_a_busy(rIdx2, 0));
            end
            vectors++;
            if (z_read1 !== exp_z_read(z_rIdx1) || z_read2 !== exp_z_read(z_rIdx2) ||
                z_busy1 !== exp_z_busy(z_rIdx1) || z_busy2 !== exp_z_busy(z_rIdx2)) begin
                miscompares++;
                $display("FAIL rand_z n=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", n,
                         z_read1, z_read2, z_busy1, z_busy2, exp_z_read(z_rIdx1),
                         exp_z_read(z_rIdx2), exp_z_busy(z_rIdx1), exp_z_busy(z_rIdx2));
            end
            vectors++;
            if (a_wConf !== ma_conf || z_wConf !== mz_conf) begin
                miscompares++;
                $display("FAIL rand_wconf n=%0d: got %b/%b want %b/%b", n, a_wConf, z_wConf,
                         ma_conf, mz_conf);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        @(negedge CLK);
        test_reset();
        test_write_read();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
